// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: line/frame counters, half-resolution coordinates,
// latency-matched syncs and colour. Optional macro VGA_BORDER_EN adds a white frame.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE     = 640,
    parameter int unsigned H_FRONT       = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BACK        = 48,
    parameter int unsigned V_VISIBLE     = 480,
    parameter int unsigned V_FRONT       = 10,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_BACK        = 33,
    parameter int unsigned PIXEL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pixel_data,
    output logic [8:0]  x,
    output logic [8:0]  y,
    output logic        clk_vsync,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic [4:0]  vga_r,
    output logic [5:0]  vga_g,
    output logic [4:0]  vga_b
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned CW_MIN  = ($clog2(H_TOTAL) > $clog2(V_TOTAL)) ? $clog2(H_TOTAL) : $clog2(V_TOTAL);
    // Coordinates are taken from bits [9:1], so the counters are never narrower than 10 bits.
    localparam int unsigned CW      = (CW_MIN > 10) ? CW_MIN : 10;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS      = CW'(H_VISIBLE);
    localparam logic [CW-1:0] V_VIS      = CW'(V_VISIBLE);
    localparam logic [CW-1:0] HS_FIRST   = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] HS_LAST    = CW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST   = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] VS_LAST    = CW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [CW-1:0]            hcnt_q, hcnt_d;
    logic [CW-1:0]            vcnt_q, vcnt_d;
    logic [8:0]               x_q, x_d;
    logic [8:0]               y_q, y_d;
    logic                     vsync_q, vsync_d;
    logic                     de_raw, hs_raw, vs_raw;
    logic [PIXEL_LATENCY-1:0] de_pipe_q, de_pipe_d;
    logic [PIXEL_LATENCY-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIXEL_LATENCY-1:0] vs_pipe_q, vs_pipe_d;
    logic                     blank_n_q, hs_q, vs_q;
    logic [15:0]              rgb_q, rgb_d;
`ifdef VGA_BORDER_EN
    localparam logic [CW-1:0] H_VIS_LAST = CW'(H_VISIBLE - 1);
    localparam logic [CW-1:0] V_VIS_LAST = CW'(V_VISIBLE - 1);
    logic                     bd_raw;
    logic [PIXEL_LATENCY-1:0] bd_pipe_q, bd_pipe_d;
`endif

    always_comb begin
        hcnt_d  = hcnt_q + 1'b1;
        vcnt_d  = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end
        x_d     = hcnt_q[9:1];
        y_d     = vcnt_q[9:1];
        vsync_d = (vcnt_q == V_VIS);
    end

    always_comb begin
        de_raw = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
        hs_raw = !((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
        vs_raw = !((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));
        // Shift toward the MSB; the cast drops the oldest tap.
        de_pipe_d = PIXEL_LATENCY'({de_pipe_q, de_raw});
        hs_pipe_d = PIXEL_LATENCY'({hs_pipe_q, hs_raw});
        vs_pipe_d = PIXEL_LATENCY'({vs_pipe_q, vs_raw});
`ifdef VGA_BORDER_EN
        bd_raw    = de_raw && ((hcnt_q == '0) || (hcnt_q == H_VIS_LAST) ||
                               (vcnt_q == '0) || (vcnt_q == V_VIS_LAST));
        bd_pipe_d = PIXEL_LATENCY'({bd_pipe_q, bd_raw});
`endif
    end

    always_comb begin
        rgb_d = '0;
        if (de_pipe_q[PIXEL_LATENCY-1]) begin
            rgb_d = pixel_data;
`ifdef VGA_BORDER_EN
            if (bd_pipe_q[PIXEL_LATENCY-1]) begin
                rgb_d = '1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            vsync_q   <= 1'b0;
            de_pipe_q <= '0;
            hs_pipe_q <= '1;
            vs_pipe_q <= '1;
            blank_n_q <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            rgb_q     <= '0;
`ifdef VGA_BORDER_EN
            bd_pipe_q <= '0;
`endif
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            vsync_q   <= vsync_d;
            de_pipe_q <= de_pipe_d;
            hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
            blank_n_q <= de_pipe_q[PIXEL_LATENCY-1];
            hs_q      <= hs_pipe_q[PIXEL_LATENCY-1];
            vs_q      <= vs_pipe_q[PIXEL_LATENCY-1];
            rgb_q     <= rgb_d;
`ifdef VGA_BORDER_EN
            bd_pipe_q <= bd_pipe_d;
`endif
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign clk_vsync   = vsync_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_r       = rgb_q[15:11];
    assign vga_g       = rgb_q[10:5];
    assign vga_b       = rgb_q[4:0];
endmodule
